// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: a WB_LATENCY-deep scoreboard of in-flight register
// writes, data/structural stall generation and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int WB_LATENCY = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] if_id_instr,
  input  logic        mem_busy,
  input  logic        flush,
  output logic        stall,
  output logic [7:0]  pending_regs,
  output logic [15:0] stall_count
);

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOVE,
    CLS_ARITH,
    CLS_MEM,
    CLS_AUDIO
  } instr_class_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic [1:0] mask;
  } sb_entry_t;

  logic         w_imm;
  logic [1:0]   w_type;
  logic [2:0]   w_op;
  logic [2:0]   w_rd;
  logic [2:0]   w_rs2;
  instr_class_e w_class;
  logic [1:0]   w_mask;
  logic         w_reads_rs1;
  logic         w_reads_rs2;
  logic         w_data_hazard;
  logic         w_struct_hazard;
  logic         w_stall;
  logic         w_insert;
  logic [7:0]   w_pending;
  logic         w_unused_bits;

  sb_entry_t    r_sb [WB_LATENCY];
  logic [15:0]  r_stall_count;

  assign w_imm  = if_id_instr[31];
  assign w_type = if_id_instr[30:29];
  assign w_op   = if_id_instr[28:26];
  assign w_rd   = if_id_instr[21:19];
  assign w_rs2  = if_id_instr[18:16];

  always_comb begin : decode
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    w_class = CLS_NOP;
    w_mask  = 2'b00;
    unique case (w_type)
      2'b01:   w_class = (w_op inside {3'b101, 3'b110, 3'b111}) ? CLS_MOVE : CLS_ARITH;
      2'b10:   w_class = CLS_MEM;
      2'b11:   w_class = CLS_AUDIO;
      default: w_class = CLS_NOP;
    endcase
    unique case (w_class)
      CLS_MOVE: begin
        if (w_op == 3'b101)      w_mask = 2'b01;
        else if (w_op == 3'b110) w_mask = 2'b10;
        else                     w_mask = 2'b11;
      end
      CLS_ARITH: w_mask = 2'b11;
      CLS_MEM: begin
        if (w_op == 3'b001)      w_mask = 2'b01;
        else if (w_op == 3'b010) w_mask = 2'b10;
        else                     w_mask = 2'b00;
      end
      default: w_mask = 2'b00;
    endcase
  end

  // Moves never read rs1; rs2 is an operand only without an immediate.
  assign w_reads_rs1 = w_class inside {CLS_ARITH, CLS_MEM, CLS_AUDIO};
  assign w_reads_rs2 = !w_imm &&
                       ((w_class inside {CLS_ARITH, CLS_MEM, CLS_AUDIO}) ||
                        (w_class == CLS_MOVE && w_op == 3'b111));

  always_comb begin : scoreboard_lookup
    w_data_hazard = 1'b0;
    w_pending     = 8'h00;
    w_unused_bits = ^{if_id_instr[25:22], if_id_instr[15:0]};
    for (int i = 0; i < WB_LATENCY; i++) begin
      if (r_sb[i].valid) begin
        w_pending[r_sb[i].rd] = 1'b1;
        if ((w_reads_rs1 && r_sb[i].rd == w_rd) ||
            (w_reads_rs2 && r_sb[i].rd == w_rs2)) begin
          w_data_hazard = 1'b1;
        end
      end
      w_unused_bits = w_unused_bits ^ (^r_sb[i].mask);
    end
  end

  assign w_struct_hazard = (w_class == CLS_MEM) && mem_busy;
  assign w_stall  = (w_data_hazard || w_struct_hazard) && !flush && (w_class != CLS_NOP);
  assign w_insert = (w_class != CLS_NOP) && (w_mask != 2'b00) && !w_stall && !flush;

  // The pipeline keeps shifting while stalled so older writes still drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset in full.
      for (int i = 0; i < WB_LATENCY; i++) r_sb[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its predecessor's pre-edge value.
      r_sb[0] <= w_insert ? sb_entry_t'{valid: 1'b1, rd: w_rd, mask: w_mask} : '0;
      for (int i = 1; i < WB_LATENCY; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= 16'h0000;
    end else if (w_stall && r_stall_count != 16'hFFFF) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall        = w_stall;
  assign pending_regs = w_pending;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, reset and
// saturation sequences, and randomized traffic against a per-register countdown model.
module tb_pipeline_hazard_ctrl;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] if_id_instr;
  logic        mem_busy;
  logic        flush;
  logic        stall;
  logic [7:0]  pending_regs;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model: cycles left until each register's latest write completes, plus stall tally.
  int left_cyc [8];
  int m_count;

  pipeline_hazard_ctrl #(.WB_LATENCY(L)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .if_id_instr  (if_id_instr),
    .mem_busy     (mem_busy),
    .flush        (flush),
    .stall        (stall),
    .pending_regs (pending_regs),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        busy;
    logic        fl;
    logic        exp_stall;
    logic [7:0]  exp_pend;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic imm, input logic [1:0] typ,
                                     input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs2);
    return {imm, typ, op, 4'b0000, rd, rs2, 16'h0000};
  endfunction

  function automatic void model_eval(input logic [31:0] ins, input logic busy, input logic fl,
                                     output bit st, output bit ins_ok);
    int  typ, op, rs1, rs2;
    bit  imm, nop, mv, ar, mem, aud, writes, rd1, rd2, haz;
    imm = ins[31];
    typ = int'(ins[30:29]);
    op  = int'(ins[28:26]);
    rs1 = int'(ins[21:19]);
    rs2 = int'(ins[18:16]);
    nop = (typ == 0);
    mv  = (typ == 1) && (op >= 5);
    ar  = (typ == 1) && (op < 5);
    mem = (typ == 2);
    aud = (typ == 3);
    writes = mv || ar || (mem && (op == 1 || op == 2));
    rd1 = ar || mem || aud;
    rd2 = !imm && (ar || mem || aud || (mv && op == 7));
    haz = (rd1 && left_cyc[rs1] > 0) || (rd2 && left_cyc[rs2] > 0);
    st  = (haz || (mem && busy)) && !fl && !nop;
    ins_ok = !nop && writes && !st && !fl;
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p = 8'h00;
    for (int r = 0; r < 8; r++) if (left_cyc[r] > 0) p[r] = 1'b1;
    return p;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 8; r++) left_cyc[r] = 0;
    m_count = 0;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic model_step(input logic [31:0] ins, input logic busy, input logic fl);
    bit st, ins_ok;
    if_id_instr = ins;
    mem_busy    = busy;
    flush       = fl;
    #1;
    model_eval(ins, busy, fl, st, ins_ok);
    check("rand_stall", {31'd0, stall}, {31'd0, st});
    check("rand_pending", {24'd0, pending_regs}, {24'd0, model_pending()});
    check("rand_count", {16'd0, stall_count}, m_count[31:0]);
    @(posedge clk);
    for (int r = 0; r < 8; r++) if (left_cyc[r] > 0) left_cyc[r]--;
    if (ins_ok) left_cyc[int'(ins[21:19])] = L;
    if (st && m_count < 65535) m_count++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    check("reset_pending", {24'd0, pending_regs}, 32'd0);
    check("reset_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] nop, add1, movl2, addi3, ldl5, add5, aud6, add4, mov7, movl4, st5, add4i;

    resetn      = 1'b0;
    if_id_instr = 32'h0;
    mem_busy    = 1'b0;
    flush       = 1'b0;
    model_clear();

    nop   = 32'h0;
    add1  = mk(1'b0, 2'b01, 3'b000, 3'd1, 3'd0);
    movl2 = mk(1'b1, 2'b01, 3'b101, 3'd2, 3'd0);
    addi3 = mk(1'b1, 2'b01, 3'b000, 3'd3, 3'd0);
    ldl5  = mk(1'b0, 2'b10, 3'b001, 3'd5, 3'd0);
    add5  = mk(1'b0, 2'b01, 3'b000, 3'd5, 3'd0);
    aud6  = mk(1'b0, 2'b11, 3'b000, 3'd6, 3'd0);
    add4  = mk(1'b0, 2'b01, 3'b000, 3'd4, 3'd0);
    mov7  = mk(1'b0, 2'b01, 3'b111, 3'd2, 3'd4);
    movl4 = mk(1'b0, 2'b01, 3'b101, 3'd4, 3'd4);
    st5   = mk(1'b0, 2'b10, 3'b000, 3'd5, 3'd0);
    add4i = mk(1'b1, 2'b01, 3'b000, 3'd4, 3'd0);

    // Dependent ADD pair: three stall cycles.
    tbl.push_back('{add1,  1'b0, 1'b0, 1'b0, 8'h00, 16'd0});
    tbl.push_back('{add1,  1'b0, 1'b0, 1'b1, 8'h02, 16'd0});
    tbl.push_back('{add1,  1'b0, 1'b0, 1'b1, 8'h02, 16'd1});
    tbl.push_back('{add1,  1'b0, 1'b0, 1'b1, 8'h02, 16'd2});
    tbl.push_back('{add1,  1'b0, 1'b0, 1'b0, 8'h00, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h02, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h02, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h02, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd3});
    // Move-lower r2 then independent ADD imm r3.
    tbl.push_back('{movl2, 1'b0, 1'b0, 1'b0, 8'h00, 16'd3});
    tbl.push_back('{addi3, 1'b0, 1'b0, 1'b0, 8'h04, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h0C, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h0C, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h08, 16'd3});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd3});
    // Load held by mem_busy for five cycles, inserted once busy drops.
    for (int i = 0; i < 5; i++)
      tbl.push_back('{ldl5, 1'b1, 1'b0, 1'b1, 8'h00, 16'(3 + i)});
    tbl.push_back('{ldl5,  1'b0, 1'b0, 1'b0, 8'h00, 16'd8});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h20, 16'd8});
    // Flushed hazarding instruction: no stall, no insertion.
    tbl.push_back('{add5,  1'b0, 1'b1, 1'b0, 8'h20, 16'd8});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h20, 16'd8});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd8});
    // Mask-00 instructions (audio, store) never enter the scoreboard.
    tbl.push_back('{aud6,  1'b0, 1'b0, 1'b0, 8'h00, 16'd8});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd8});
    // rs2 hazard through move-111; move-101 reads nothing.
    tbl.push_back('{add4,  1'b0, 1'b0, 1'b0, 8'h00, 16'd8});
    tbl.push_back('{mov7,  1'b0, 1'b0, 1'b1, 8'h10, 16'd8});
    tbl.push_back('{movl4, 1'b0, 1'b0, 1'b0, 8'h10, 16'd9});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h10, 16'd9});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h10, 16'd9});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h10, 16'd9});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd9});
    tbl.push_back('{st5,   1'b0, 1'b0, 1'b0, 8'h00, 16'd9});
    tbl.push_back('{nop,   1'b0, 1'b0, 1'b0, 8'h00, 16'd9});

    // Reset while clock runs: outputs must already be clear.
    repeat (2) @(negedge clk);
    #2;
    check("por_pending", {24'd0, pending_regs}, 32'd0);
    check("por_count", {16'd0, stall_count}, 32'd0);
    check("por_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      if_id_instr = tbl[i].instr;
      mem_busy    = tbl[i].busy;
      flush       = tbl[i].fl;
      #1;
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].exp_stall});
      check($sformatf("vec%0d_pending", i), {24'd0, pending_regs}, {24'd0, tbl[i].exp_pend});
      check($sformatf("vec%0d_count", i), {16'd0, stall_count}, {16'd0, tbl[i].exp_cnt});
      @(negedge clk);
    end

    // Mid-operation reset with r1 and r4 in flight and a hazard in decode.
    if_id_instr = add1;
    @(negedge clk);
    if_id_instr = add4i;
    @(negedge clk);
    if_id_instr = add1;
    mem_busy    = 1'b0;
    flush       = 1'b0;
    #1;
    check("midrst_pre_pending", {24'd0, pending_regs}, 32'h12);
    check("midrst_pre_stall", {31'd0, stall}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_pending", {24'd0, pending_regs}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_first_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_pending", {24'd0, pending_regs}, 32'h02);
    @(negedge clk);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      ins = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      model_step(ins, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    // Saturation: a load held off by mem_busy for 70000 cycles.
    do_reset();
    if_id_instr = ldl5;
    mem_busy    = 1'b1;
    flush       = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", {16'd0, stall_count}, 32'h0000FFFE);
    @(posedge clk);
    @(negedge clk);
    check("sat_ffff", {16'd0, stall_count}, 32'h0000FFFF);
    repeat (70000 - 65535) @(posedge clk);
    @(negedge clk);
    check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
    check("sat_stall", {31'd0, stall}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
